// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind valid/ready request and response channels with fixed latency.
// Define DMEM_OOR_ERR_EN to fault accesses whose address bits above the RAM range are non-zero.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic          accept;
    logic          enter_resp;
    logic          cur_we;
    logic [1:0]    cur_size;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_idx;
    logic          misalign;
    logic          oor;
    logic          err_d;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rsp_rdata_d;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // With LATENCY == 1 the RESP entry edge is the accept edge, so the live request is used then.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_size  = (state_q == IDLE) ? req_size  : size_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_idx   = cur_addr[AW+1:2];

    assign enter_resp = rst_n && (((state_q == IDLE) && accept && (LATENCY == 1)) ||
                                  ((state_q == WAIT) && (cnt_q == 4'd1)));

`ifdef DMEM_OOR_ERR_EN
    assign oor = (cur_addr >> (AW + 2)) != 32'd0;
`else
    logic unused_addr_hi;
    assign oor            = 1'b0;
    assign unused_addr_hi = ^cur_addr[31:AW+2];
`endif

    always_comb begin
        misalign  = 1'b0;
        be        = 4'b0000;
        wdata_rep = cur_wdata;
        case (cur_size)
            2'b00: begin
                be        = 4'b0001 << cur_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                misalign  = cur_addr[0];
                be        = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                misalign  = |cur_addr[1:0];
                be        = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

    assign err_d  = misalign || oor;
    assign mem_we = enter_resp && cur_we && !err_d;

    // One byte-wide RAM per lane keeps the masked write a plain per-lane enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we && be[gi]) begin
                mem[cur_idx] <= wdata_rep[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = mem[cur_idx];
    end

    assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

    always_comb begin
        rsp_rdata_d = 32'd0;
        if (!err_d && !cur_we) begin
            case (cur_size)
                2'b00:   rsp_rdata_d = {24'd0, rd_shift[7:0]};
                2'b01:   rsp_rdata_d = {16'd0, rd_shift[15:0]};
                2'b10:   rsp_rdata_d = rd_shift;
                default: rsp_rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= err_d;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
